// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter over four WIDTH-bit lanes feeding one registered valid/ready output.
// The winner's word is captured at its grant edge; the winner gets a one-cycle ack when the word is accepted.
module rr_mux4_arbiter #(
   parameter int WIDTH    = 32,
   parameter int HOLD_MAX = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] in,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         sel,
   output logic [3:0]         grant,
   output logic [3:0]         ack,
   output logic               stall
);

   localparam int CW = $clog2(HOLD_MAX + 1);

   // Handshake: a word transfers on a rising edge where out_valid && out_ready;
   // out_data, sel and grant stay stable while out_valid is high and out_ready is low.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        sel_q, sel_d;
   logic [3:0]        grant_q, grant_d;
   logic [3:0]        ack_q, ack_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              stall_q, stall_d;

   logic [WIDTH-1:0]  lane [4];
   logic [1:0]        win;
   logic              load;
   logic              hs;
   logic [3:0]        masked;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      assign lane[g] = in[WIDTH*g +: WIDTH];
   end

   // First set bit of r scanning p, p+1, p+2, p+3 (mod 4); caller guarantees r != 0.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      pick = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      data_d  = data_q;
      ack_d   = '0;
      cnt_d   = '0;
      win     = ptr_q;
      load    = 1'b0;
      masked  = '0;
      hs      = (state_q == BUSY) && out_ready;

      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (req != 4'b0000) begin
               win  = pick(req, ptr_q);
               load = 1'b1;
            end
         end
         BUSY: begin
            if (hs) begin
               ack_d  = grant_q;
               ptr_d  = sel_q + 2'd1;
               masked = req & ~grant_q;
               if (masked != 4'b0000) begin
                  win  = pick(masked, ptr_d);
                  load = 1'b1;
               end else if (req != 4'b0000) begin
                  // Only the just-served lane still asks: serve it again.
                  win  = sel_q;
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else begin
               cnt_d = (cnt_q < CW'(HOLD_MAX)) ? cnt_q + CW'(1) : cnt_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         state_d = BUSY;
         sel_d   = win;
         grant_d = 4'b0001 << win;
         data_d  = lane[win];
      end

      stall_d = (cnt_d >= CW'(HOLD_MAX));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign out_valid = (state_q == BUSY);
   assign out_data  = data_q;
   assign sel       = sel_q;
   assign grant     = grant_q;
   assign ack       = ack_q;
   assign stall     = stall_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: reset, single transfer, rotation, backpressure/stall,
// data stability, pointer wrap, regrant of a lone requester and reset mid-transfer.
module tb_rr_mux4_arbiter;

   localparam int WIDTH    = 32;
   localparam int HOLD_MAX = 8;

   logic               clk;
   logic               reset;
   logic [3:0]         req;
   logic [WIDTH-1:0]   lane [4];
   logic [4*WIDTH-1:0] in_bus;
   logic               out_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         sel;
   logic [3:0]         grant;
   logic [3:0]         ack;
   logic               stall;

   int tests_run    = 0;
   int tests_failed = 0;

   assign in_bus = {lane[3], lane[2], lane[1], lane[0]};

   rr_mux4_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .in        (in_bus),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .grant     (grant),
      .ack       (ack),
      .stall     (stall)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Outputs are checked and inputs changed 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = 4'b0000;
      out_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req = 4'b0000;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) lane[i] = 32'hFFFF_FFFF;
      step();
      step();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      tests_run++; if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", out_data); end
      tests_run++; if (sel !== 2'd0) begin tests_failed++; $display("FAIL reset_sel: got %0d want 0", sel); end
      tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", grant); end
      tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack: got %b want 0000", ack); end
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b want 0", stall); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      lane[2] = 32'hDEADBEEF;
      req = 4'b0100;
      out_ready = 1'b1;
      step();
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %0b want 1", out_valid); end
      tests_run++; if (sel !== 2'd2) begin tests_failed++; $display("FAIL single_sel: got %0d want 2", sel); end
      tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL single_grant: got %b want 0100", grant); end
      tests_run++; if (out_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_data: got %h want deadbeef", out_data); end
      tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL single_early_ack: got %b want 0000", ack); end
      req = 4'b0000;
      step();
      tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL single_ack: got %b want 0100", ack); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle_valid: got %0b want 0", out_valid); end
      tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL single_idle_grant: got %b want 0000", grant); end
      tests_run++; if (sel !== 2'd2) begin tests_failed++; $display("FAIL single_idle_sel: got %0d want 2", sel); end
      step();
      tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
   endtask

   task automatic test_rotation();
      logic [1:0] es;
      logic [3:0] eack;
      do_reset();
      lane[0] = 32'd11; lane[1] = 32'd22; lane[2] = 32'd33; lane[3] = 32'd44;
      req = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         es   = 2'(k % 4);
         eack = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
         tests_run++; if (sel !== es) begin tests_failed++; $display("FAIL rot_sel[%0d]: got %0d want %0d", k, sel, es); end
         tests_run++; if (grant !== (4'b0001 << es)) begin tests_failed++; $display("FAIL rot_grant[%0d]: got %b want %b", k, grant, 4'b0001 << es); end
         tests_run++; if (out_data !== 32'd11 * (32'(es) + 32'd1)) begin tests_failed++; $display("FAIL rot_data[%0d]: got %0d want %0d", k, out_data, 32'd11 * (32'(es) + 32'd1)); end
         tests_run++; if (ack !== eack) begin tests_failed++; $display("FAIL rot_ack[%0d]: got %b want %b", k, ack, eack); end
      end
      req = 4'b0000;
      step();
      tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL rot_last_ack: got %b want 0001", ack); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rot_idle: got %0b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      lane[1] = 32'd7;
      req = 4'b0010;
      out_ready = 1'b0;
      step();
      tests_run++; if (sel !== 2'd1 || grant !== 4'b0010) begin tests_failed++; $display("FAIL bp_grant: got sel=%0d grant=%b want sel=1 grant=0010", sel, grant); end
      for (int i = 1; i <= 10; i++) begin
         step();
         tests_run++; if (out_data !== 32'd7) begin tests_failed++; $display("FAIL bp_data[%0d]: got %0d want 7", i, out_data); end
         tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL bp_ack[%0d]: got %b want 0000", i, ack); end
         tests_run++; if (stall !== (i >= HOLD_MAX)) begin tests_failed++; $display("FAIL bp_stall[%0d]: got %0b want %0b", i, stall, i >= HOLD_MAX); end
      end
      out_ready = 1'b1;
      req = 4'b0000;
      step();
      tests_run++; if (ack !== 4'b0010) begin tests_failed++; $display("FAIL bp_release_ack: got %b want 0010", ack); end
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL bp_release_stall: got %0b want 0", stall); end
   endtask

   task automatic test_data_stability();
      lane[3] = 32'd5;
      req = 4'b1000;
      out_ready = 1'b0;
      step();
      tests_run++; if (sel !== 2'd3 || out_data !== 32'd5) begin tests_failed++; $display("FAIL stab_grant: got sel=%0d data=%0d want sel=3 data=5", sel, out_data); end
      lane[3] = 32'd9;
      step();
      step();
      tests_run++; if (out_data !== 32'd5) begin tests_failed++; $display("FAIL stab_data: got %0d want 5", out_data); end
   endtask

   task automatic test_priority_wrap();
      lane[0] = 32'h100;
      req = 4'b1001;
      out_ready = 1'b1;
      step();
      tests_run++; if (ack !== 4'b1000) begin tests_failed++; $display("FAIL wrap_ack: got %b want 1000", ack); end
      tests_run++; if (sel !== 2'd0 || grant !== 4'b0001) begin tests_failed++; $display("FAIL wrap_grant: got sel=%0d grant=%b want sel=0 grant=0001", sel, grant); end
      tests_run++; if (out_data !== 32'h100) begin tests_failed++; $display("FAIL wrap_data: got %h want 100", out_data); end
      req = 4'b0000;
      step();
      tests_run++; if (ack !== 4'b0001 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_done: got ack=%b valid=%0b want ack=0001 valid=0", ack, out_valid); end
   endtask

   task automatic test_back_to_back_same_lane();
      lane[2] = 32'hA;
      req = 4'b0100;
      out_ready = 1'b1;
      step();
      lane[2] = 32'hB;
      step();
      tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL regrant_ack: got %b want 0100", ack); end
      tests_run++; if (out_valid !== 1'b1 || grant !== 4'b0100 || out_data !== 32'hB) begin tests_failed++; $display("FAIL regrant_word: got valid=%0b grant=%b data=%h want 1 0100 b", out_valid, grant, out_data); end
      req = 4'b0000;
      step();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL regrant_idle: got %0b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_transfer();
      lane[1] = 32'h55;
      req = 4'b0010;
      out_ready = 1'b0;
      step();
      step();
      step();
      tests_run++; if (sel !== 2'd1 || out_data !== 32'h55) begin tests_failed++; $display("FAIL mid_grant: got sel=%0d data=%h want sel=1 data=55", sel, out_data); end
      reset = 1'b1;
      step();
      tests_run++; if (out_valid !== 1'b0 || out_data !== 32'h0 || sel !== 2'd0) begin tests_failed++; $display("FAIL mid_reset_out: got valid=%0b data=%h sel=%0d want 0 0 0", out_valid, out_data, sel); end
      tests_run++; if (grant !== 4'b0000 || ack !== 4'b0000 || stall !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ctl: got grant=%b ack=%b stall=%0b want 0000 0000 0", grant, ack, stall); end
      reset = 1'b0;
      lane[0] = 32'hA0;
      lane[1] = 32'hA1;
      req = 4'b0011;
      step();
      tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL mid_no_ack: got %b want 0000", ack); end
      tests_run++; if (sel !== 2'd0 || grant !== 4'b0001 || out_data !== 32'hA0) begin tests_failed++; $display("FAIL mid_lane0: got sel=%0d grant=%b data=%h want 0 0001 a0", sel, grant, out_data); end
      out_ready = 1'b1;
      step();
      tests_run++; if (ack !== 4'b0001 || sel !== 2'd1 || out_data !== 32'hA1) begin tests_failed++; $display("FAIL mid_next: got ack=%b sel=%0d data=%h want 0001 1 a1", ack, sel, out_data); end
      req = 4'b0000;
      step();
      tests_run++; if (ack !== 4'b0010 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_done: got ack=%b valid=%0b want 0010 0", ack, out_valid); end
   endtask

   initial begin
      reset = 1'b1;
      req = 4'b0000;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) lane[i] = '0;
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_data_stability();
      test_priority_wrap();
      test_back_to_back_same_lane();
      test_reset_mid_transfer();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
